// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
package fifo_pkg;

  // Occupancy of the two-word skid store.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } rd_state_e;

  localparam int unsigned DEF_CNT_WIDTH = 16;

endpackage : fifo_pkg

// File: rtl/fifo_reader.sv
// fifo_reader: pops words from a show-ahead FIFO into a 2-entry skid store and
// presents them as a valid/ready stream, counting delivered words.
// Ports:
//   i_rclk, i_rrst_n    read-domain clock, synchronous active-low reset
//   i_buf_empty/i_rdata FIFO empty flag and head word
//   o_r_en              FIFO pop strobe (combinational from registered state)
//   i_flush             discard locally held words
//   o_valid/o_data      stream output, i_ready downstream accept
//   o_count             number of words transferred downstream (wraps)
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned BUF_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 i_rclk,
  input  logic                 i_rrst_n,
  input  logic                 i_buf_empty,
  input  logic [BUF_WIDTH-1:0] i_rdata,
  output logic                 o_r_en,
  input  logic                 i_flush,
  output logic                 o_valid,
  output logic [BUF_WIDTH-1:0] o_data,
  input  logic                 i_ready,
  output logic [CNT_WIDTH-1:0] o_count
);

  rd_state_e            state, state_d;
  logic [BUF_WIDTH-1:0] head, head_d;
  logic [BUF_WIDTH-1:0] tail, tail_d;
  logic [CNT_WIDTH-1:0] count, count_d;
  logic                 pop;
  logic                 xfer;

  // State and storage registers.
  always_ff @(posedge i_rclk) begin
    if (!i_rrst_n) begin
      state <= S_EMPTY;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_d;
      head  <= head_d;
      tail  <= tail_d;
      count <= count_d;
    end
  end

  // Next-state logic; pop depends only on FIFO flags and local state, never on i_ready.
  always_comb begin
    state_d = state;
    head_d  = head;
    tail_d  = tail;
    count_d = count;
    pop     = i_rrst_n && !i_buf_empty && (state != S_TWO) && !i_flush;
    xfer    = (state != S_EMPTY) && i_ready;

    if (i_flush) begin
      state_d = S_EMPTY;
    end else begin
      if (xfer) count_d = count + CNT_WIDTH'(1);
      case (state)
        S_EMPTY: begin
          if (pop) begin
            head_d  = i_rdata;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          // Simultaneous pop and transfer: new word replaces the departing head.
          if (pop && xfer) begin
            head_d = i_rdata;
          end else if (pop) begin
            tail_d  = i_rdata;
            state_d = S_TWO;
          end else if (xfer) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (xfer) begin
            head_d  = tail;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  assign o_r_en  = pop;
  assign o_valid = (state != S_EMPTY);
  assign o_data  = head;
  assign o_count = count;

endmodule : fifo_reader

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a vector table for single-cycle behaviour plus
// sequences driven from a queue that models the upstream show-ahead FIFO.
module tb_fifo_reader;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       buf_empty = 1'b1;
  logic [7:0] rdata     = 8'h00;
  logic       flush     = 1'b0;
  logic       ready     = 1'b0;
  logic       r_en, valid;
  logic [7:0] data;
  logic [15:0] count;
  logic       r_en4, valid4;
  logic [7:0] data4;
  logic [3:0] count4;

  int n_vec = 0;
  int n_err = 0;
  int pops  = 0;
  logic [7:0] src[$];
  logic [7:0] got[$];

  always #5 clk = ~clk;

  fifo_reader dut (
    .i_rclk(clk), .i_rrst_n(rst_n), .i_buf_empty(buf_empty), .i_rdata(rdata),
    .o_r_en(r_en), .i_flush(flush), .o_valid(valid), .o_data(data),
    .i_ready(ready), .o_count(count)
  );

  fifo_reader #(.BUF_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .i_rclk(clk), .i_rrst_n(rst_n), .i_buf_empty(buf_empty), .i_rdata(rdata),
    .o_r_en(r_en4), .i_flush(flush), .o_valid(valid4), .o_data(data4),
    .i_ready(ready), .o_count(count4)
  );

  typedef struct packed {
    logic        rst_n;
    logic        empty;
    logic [7:0]  rdata;
    logic        flush;
    logic        ready;
    logic        r_en;
    logic        valid;
    logic [7:0]  data;   // compared only when valid is expected
    logic [15:0] count;
  } vec_t;

  vec_t vecs [0:12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present the queue head as the FIFO output.
  task automatic refresh();
    buf_empty = (src.size() == 0);
    rdata     = (src.size() == 0) ? 8'h00 : src[0];
  endtask

  // One clock: note pop/transfer before the edge, update the FIFO model after it.
  task automatic tick();
    logic popped;
    logic moved;
    logic [7:0] word;
    chk("no_pop_when_empty", {31'd0, r_en & buf_empty}, 32'd0);
    popped = r_en;
    moved  = valid && ready && !flush && rst_n;
    word   = data;
    @(posedge clk);
    #1;
    if (popped) begin
      void'(src.pop_front());
      pops++;
    end
    if (moved) got.push_back(word);
    refresh();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    src.delete();
    refresh();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    //          rst   emp   rdata  fl    rdy   r_en  vld   data   count
    vecs[0]  = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 8'h21, 1'b0, 1'b0, 1'b1, 1'b1, 8'h21, 16'd0};
    vecs[3]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h21, 16'd0};
    vecs[4]  = '{1'b1, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 16'd0};
    vecs[5]  = '{1'b1, 1'b0, 8'h23, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 16'd1};
    vecs[6]  = '{1'b1, 1'b0, 8'h23, 1'b0, 1'b1, 1'b1, 1'b1, 8'h23, 16'd2};
    vecs[7]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd3};
    vecs[8]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd3};
    vecs[9]  = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd3};
    vecs[10] = '{1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 16'd3};
    vecs[11] = '{1'b0, 1'b0, 8'h45, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[12] = '{1'b0, 1'b0, 8'h46, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};

    for (int i = 0; i < 13; i++) begin
      rst_n = vecs[i].rst_n; buf_empty = vecs[i].empty; rdata = vecs[i].rdata;
      flush = vecs[i].flush; ready = vecs[i].ready;
      #1;
      chk($sformatf("vec%0d_r_en", i), {31'd0, r_en}, {31'd0, vecs[i].r_en});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].valid});
      if (vecs[i].valid) chk($sformatf("vec%0d_data", i), {24'd0, data}, {24'd0, vecs[i].data});
      chk($sformatf("vec%0d_count", i), {16'd0, count}, {16'd0, vecs[i].count});
    end

    // Streaming at one word per cycle.
    do_reset();
    ready = 1'b1;
    pops = 0; got.delete();
    for (int k = 0; k < 8; k++) src.push_back(8'(8'h11 + k));
    refresh(); #1;
    for (int k = 0; k < 8; k++) begin
      chk("stream_r_en", {31'd0, r_en}, 32'd1);
      tick();
      chk("stream_head", {23'd0, valid, data}, {23'd0, 1'b1, 8'(8'h11 + k)});
      chk("stream_count", {16'd0, count}, k);
    end
    chk("stream_r_en_done", {31'd0, r_en}, 32'd0);
    tick();
    chk("stream_valid_end", {31'd0, valid}, 32'd0);
    chk("stream_count_end", {16'd0, count}, 32'd8);
    chk("stream_pops", pops, 32'd8);
    chk("stream_got_n", got.size(), 32'd8);
    for (int k = 0; k < 8 && k < got.size(); k++)
      chk("stream_order", {24'd0, got[k]}, {24'd0, 8'(8'h11 + k)});

    // Backpressure: only two pops fill the store, head holds.
    ready = 1'b0;
    pops = 0; got.delete();
    for (int k = 0; k < 5; k++) src.push_back(8'(8'h31 + k));
    refresh(); #1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("bp_head_stable", {23'd0, valid, data}, {23'd0, 1'b1, 8'h31});
    end
    chk("bp_pops", pops, 32'd2);
    chk("bp_r_en_low", {31'd0, r_en}, 32'd0);
    ready = 1'b1; #1;
    for (int c = 0; c < 20 && (src.size() != 0 || valid); c++) tick();
    chk("bp_got_n", got.size(), 32'd5);
    for (int k = 0; k < 5 && k < got.size(); k++)
      chk("bp_order", {24'd0, got[k]}, {24'd0, 8'(8'h31 + k)});
    chk("bp_count", {16'd0, count}, 32'd13);

    // Empty boundary: a single word.
    pops = 0; got.delete();
    src.push_back(8'hA5);
    refresh(); #1;
    tick();
    chk("eb_head", {23'd0, valid, data}, {23'd0, 1'b1, 8'hA5});
    tick();
    chk("eb_valid_fall", {31'd0, valid}, 32'd0);
    tick();
    chk("eb_r_en_low", {31'd0, r_en}, 32'd0);
    tick();
    chk("eb_pops", pops, 32'd1);
    chk("eb_got_n", got.size(), 32'd1);
    if (got.size() > 0) chk("eb_word", {24'd0, got[0]}, 32'hA5);
    chk("eb_count", {16'd0, count}, 32'd14);

    // Flush from TWO with a coincident (uncounted) transfer.
    ready = 1'b0;
    pops = 0; got.delete();
    for (int k = 0; k < 4; k++) src.push_back(8'(8'h51 + k));
    refresh(); #1;
    tick();
    tick();
    chk("fl_two_head", {23'd0, valid, data}, {23'd0, 1'b1, 8'h51});
    chk("fl_two_pops", pops, 32'd2);
    flush = 1'b1; ready = 1'b1; #1;
    chk("fl_r_en_sup", {31'd0, r_en}, 32'd0);
    tick();
    flush = 1'b0; #1;
    chk("fl_valid", {31'd0, valid}, 32'd0);
    chk("fl_count", {16'd0, count}, 32'd14);
    chk("fl_pops", pops, 32'd2);
    tick();
    chk("fl_next_head", {23'd0, valid, data}, {23'd0, 1'b1, 8'h53});
    tick();
    chk("fl_got_n", got.size(), 32'd1);
    if (got.size() > 0) chk("fl_word", {24'd0, got[0]}, 32'h53);
    chk("fl_count_after", {16'd0, count}, 32'd15);
    for (int c = 0; c < 10 && (src.size() != 0 || valid); c++) tick();

    // Counter wrap on the 4-bit instance.
    do_reset();
    ready = 1'b1;
    got.delete();
    n = 0;
    for (int k = 0; k < 17; k++) src.push_back(8'(8'h60 + k));
    refresh(); #1;
    for (int c = 0; c < 40 && (src.size() != 0 || valid); c++) begin
      tick();
      if (got.size() != n) begin
        n = got.size();
        chk("wrap_count4", {28'd0, count4}, n % 16);
        chk("wrap_count16", {16'd0, count}, n);
      end
    end
    chk("wrap_total", n, 32'd17);
    chk("wrap_final4", {28'd0, count4}, 32'd1);
    for (int k = 0; k < 17 && k < got.size(); k++)
      chk("wrap_order", {24'd0, got[k]}, {24'd0, 8'(8'h60 + k)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fifo_reader
